// File: rtl/mips_pc_pkg.sv
// Shared constants and next-PC select encoding for the MIPS fetch-stage PC sequencer.
package mips_pc_pkg;

  localparam int unsigned PC_WIDTH = 32;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

  // Source of the PC loaded at the next edge, in no particular priority order.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_SEQ  = 2'd1,
    SEL_TGT  = 2'd2,
    SEL_EXC  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_incr.sv
// Combinational sequential-PC adder; the carry out of the top bit is discarded.
module pc_incr
  import mips_pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned STEP  = 4
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = pc_i + WIDTH'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter for the fetch stage: chooses between hold, sequential,
// redirect-target and exception-vector sources, advancing only on a fetch handshake.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int unsigned     WIDTH      = PC_WIDTH,
  parameter int unsigned     STEP       = 4,
  parameter int unsigned     ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             exception,
  input  logic             fetch_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             pc_valid,
  output logic             misaligned
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q;
  logic             misaligned_q, misaligned_d;
  logic             tgtMisaligned;
  pc_sel_e          sel;

  pc_incr #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_pc_incr (
    .pc_i  (pc_q),
    .sum_o (pc_next_seq)
  );

  // With ALIGN_BITS=0 every target is accepted and the misaligned pulse never fires.
  if (ALIGN_BITS > 0) begin : gAlign
    assign tgtMisaligned = |target[ALIGN_BITS-1:0];
  end else begin : gNoAlign
    assign tgtMisaligned = 1'b0;
  end

  // Exceptions and redirects take effect even while stalled or without fetch_ready.
  always_comb begin
    sel          = SEL_HOLD;
    misaligned_d = 1'b0;
    if (exception) begin
      sel = SEL_EXC;
    end else if (redirect && tgtMisaligned) begin
      sel          = SEL_EXC;
      misaligned_d = 1'b1;
    end else if (redirect) begin
      sel = SEL_TGT;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (valid_q && fetch_ready) begin
      sel = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_SEQ:  pc_d = pc_next_seq;
      SEL_TGT:  pc_d = target;
      SEL_EXC:  pc_d = EXC_VEC;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q         <= RESET_VEC;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      valid_q      <= 1'b1;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a default 32-bit instance (directed + random traffic) and an
// 8-bit, step-1, unaligned instance for wrap-around, each checked against a plain model.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance, default parameters
  logic        rnA = 1'b0, stA = 1'b0, rdA = 1'b0, exA = 1'b0, frA = 1'b0;
  logic [31:0] tgA = '0;
  logic [31:0] pcA, seqA;
  logic        validA, misA;

  // 8-bit instance, STEP=1, no alignment check
  logic        rnB = 1'b0, stB = 1'b0, rdB = 1'b0, exB = 1'b0, frB = 1'b0;
  logic [7:0]  tgB = '0;
  logic [7:0]  pcB, seqB;
  logic        validB, misB;

  pc_sequencer dutA (
    .clk         (clk),
    .reset_n     (rnA),
    .stall       (stA),
    .redirect    (rdA),
    .target      (tgA),
    .exception   (exA),
    .fetch_ready (frA),
    .pc          (pcA),
    .pc_next_seq (seqA),
    .pc_valid    (validA),
    .misaligned  (misA)
  );

  pc_sequencer #(
    .WIDTH      (8),
    .STEP       (1),
    .ALIGN_BITS (0)
  ) dutB (
    .clk         (clk),
    .reset_n     (rnB),
    .stall       (stB),
    .redirect    (rdB),
    .target      (tgB),
    .exception   (exB),
    .fetch_ready (frB),
    .pc          (pcB),
    .pc_next_seq (seqB),
    .pc_valid    (validB),
    .misaligned  (misB)
  );

  int errorCount = 0;
  int checkCount = 0;

  // Reference state: the PC as a plain number, reduced modulo 2^WIDTH after each add.
  longint unsigned mPcA = 0, mPcB = 0;
  bit              mValidA = 0, mValidB = 0, mMisA = 0, mMisB = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock of the 32-bit instance: drive at negedge, update model, check after the edge.
  task automatic applyStimulus(input bit rn, input bit st, input bit rd, input logic [31:0] tg,
                               input bit ex, input bit fr);
    @(negedge clk);
    rnA = rn; stA = st; rdA = rd; tgA = tg; exA = ex; frA = fr;
    #1;
    checkOutput("A.pc_next_seq", 64'(seqA), 64'((mPcA + 4) % 64'h1_0000_0000));
    if (!rn) begin
      mPcA = 0; mValidA = 0; mMisA = 0;
    end else begin
      mMisA = 0;
      if (ex) mPcA = 32'h80;
      else if (rd && (tg % 4 != 0)) begin mPcA = 32'h80; mMisA = 1; end
      else if (rd) mPcA = tg;
      else if (st) mPcA = mPcA;
      else if (mValidA && fr) mPcA = (mPcA + 4) % 64'h1_0000_0000;
      mValidA = 1;
    end
    @(posedge clk);
    #1;
    checkOutput("A.pc", 64'(pcA), 64'(mPcA));
    checkOutput("A.pc_valid", 64'(validA), 64'(mValidA));
    checkOutput("A.misaligned", 64'(misA), 64'(mMisA));
  endtask

  task automatic applyStimulusB(input bit rn, input bit st, input bit rd, input logic [7:0] tg,
                                input bit ex, input bit fr);
    @(negedge clk);
    rnB = rn; stB = st; rdB = rd; tgB = tg; exB = ex; frB = fr;
    #1;
    checkOutput("B.pc_next_seq", 64'(seqB), 64'((mPcB + 1) % 256));
    if (!rn) begin
      mPcB = 0; mValidB = 0; mMisB = 0;
    end else begin
      if (ex) mPcB = 8'h80;
      else if (rd) mPcB = tg;
      else if (st) mPcB = mPcB;
      else if (mValidB && fr) mPcB = (mPcB + 1) % 256;
      mValidB = 1;
    end
    @(posedge clk);
    #1;
    checkOutput("B.pc", 64'(pcB), 64'(mPcB));
    checkOutput("B.pc_valid", 64'(validB), 64'(mValidB));
    checkOutput("B.misaligned", 64'(misB), 64'(mMisB));
  endtask

  initial begin
    logic [31:0] tg;

    // Reset for two cycles, then release: valid rises, pc stays at the reset vector
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1);

    // Sequential fetches
    repeat (4) applyStimulus(1, 0, 0, 32'h0, 0, 1);

    // Stall holds at 8, then resumes
    applyStimulus(1, 0, 1, 32'h8, 0, 1);
    repeat (3) applyStimulus(1, 1, 0, 32'h0, 0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1);

    // No handshake: pc holds
    applyStimulus(1, 0, 0, 32'h0, 0, 0);

    // Redirect beats stall
    applyStimulus(1, 1, 1, 32'h100, 0, 0);

    // Misaligned redirect pulses for one cycle only
    applyStimulus(1, 0, 1, 32'h102, 0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 0);

    // Exception beats the misaligned redirect and suppresses the pulse
    applyStimulus(1, 0, 1, 32'h102, 1, 1);

    // Wrap of the 32-bit sequential path
    applyStimulus(1, 0, 1, 32'hFFFF_FFFC, 0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1);

    // Reset mid-stall and mid-redirect
    applyStimulus(1, 1, 0, 32'h0, 0, 1);
    applyStimulus(0, 1, 1, 32'h200, 0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0:       tg = 32'hFFFF_FFFC;
        1:       tg = $urandom;
        default: tg = {$urandom_range(0, 32'h3FFF), 2'b00};
      endcase
      applyStimulus(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), tg,
                    ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
    end

    // 8-bit instance: wrap from 0xFF to 0x00, then reset mid-sequence
    applyStimulusB(0, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 1, 8'hFE, 0, 1);
    applyStimulusB(1, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 1, 8'h33, 0, 1);
    applyStimulusB(0, 0, 0, 8'h0, 0, 1);
    applyStimulusB(1, 0, 0, 8'h0, 1, 1);
    for (int i = 0; i < 150; i++) begin
      applyStimulusB(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 5) == 0), 8'($urandom),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
